mu_position_writeback_sequencer: RTL

- Drives the Motion Update (MU) side of the 64-cell position cache array.
- Walks every cell (1,1,1)..(4,4,4) and, within each cell, every particle slot; reads the particle's offset tuple and consumes one signed displacement per particle.
- Computes the new in-cell offset and the destination cell, with periodic wrap on a 4x4x4 grid.
- Issues one MU write (data, destination cell, valid) per particle to the cache array.

---
 rtl/mu_position_writeback_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mu_position_writeback_sequencer.sv
// Motion-update sequencer: walks all 64 cells and their particle slots, applies one signed
// displacement per particle with periodic wrap, and issues one write per particle to the cache.
module mu_position_writeback_sequencer #(
   parameter int NUM_CELLS             = 64,
   parameter int CELLS_PER_DIM         = 4,
   parameter int DATA_WIDTH            = 29,
   parameter int CELL_ID_WIDTH         = 3,
   parameter int NUM_PARTICLE_PER_CELL = 128,
   parameter int PARTICLE_ID_WIDTH     = 7
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [NUM_CELLS*3*DATA_WIDTH-1:0]     pos_data_out,
   input  logic [3*DATA_WIDTH-1:0]               disp_data,
   input  logic                                  disp_valid,
   output logic                                  disp_ready,
   output logic                                  Motion_Update_enable,
   output logic                                  MU_rden,
   output logic [PARTICLE_ID_WIDTH-1:0]          MU_rd_addr,
   output logic [3*DATA_WIDTH-1:0]               MU_wr_data,
   output logic [3*CELL_ID_WIDTH-1:0]            MU_dst_cell,
   output logic                                  MU_wr_data_valid,
   output logic                                  busy,
   output logic                                  done,
   output logic [15:0]                           particles_moved
);

   localparam int TUPLE_W = 3 * DATA_WIDTH;
   localparam int SUM_W   = DATA_WIDTH + 2;
   localparam int CW      = $clog2(CELLS_PER_DIM);

   // Displacement handshake: a displacement is consumed on a cycle where disp_valid && disp_ready;
   // disp_ready is high only in CALC, and the producer holds disp_data stable until it is consumed.
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE, S_NEXT_CELL, S_DONE
   } state_t;

   state_t                     state, state_nxt;
   logic [CW-1:0]              cx, cy, cz;
   logic [PARTICLE_ID_WIDTH-1:0] slot;
   logic [TUPLE_W-1:0]         tuple_q, wr_data_q, rd_tuple, calc_off;
   logic [3*CELL_ID_WIDTH-1:0] dst_q, calc_dst;
   logic [3*CW-1:0]            cur_cell, calc_cell;
   logic [15:0]                moved_q;
   logic [SUM_W-1:0]           sum;
   logic [CW-1:0]              coord;
   logic                       last_slot, last_cell, cell_changed;

   // Zero-based coordinates concatenate directly into the linear cell index (x fastest).
   assign cur_cell  = {cz, cy, cx};
   assign rd_tuple  = pos_data_out[int'(cur_cell)*TUPLE_W +: TUPLE_W];
   assign last_slot = (slot == PARTICLE_ID_WIDTH'(NUM_PARTICLE_PER_CELL - 1));
   assign last_cell = (cx == CW'(CELLS_PER_DIM - 1)) && (cy == CW'(CELLS_PER_DIM - 1)) &&
                      (cz == CW'(CELLS_PER_DIM - 1));

   always_comb begin
      calc_off  = '0;
      calc_cell = '0;
      calc_dst  = '0;
      sum       = '0;
      coord     = '0;
      for (int a = 0; a < 3; a++) begin
         sum = {2'b00, tuple_q[a*DATA_WIDTH +: DATA_WIDTH]} +
               {{2{disp_data[a*DATA_WIDTH + DATA_WIDTH - 1]}}, disp_data[a*DATA_WIDTH +: DATA_WIDTH]};
         calc_off[a*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
         coord = cur_cell[a*CW +: CW];
         if (sum[SUM_W-1]) begin
            coord = (coord == '0) ? CW'(CELLS_PER_DIM - 1) : coord - CW'(1);
         end else if (sum[DATA_WIDTH]) begin
            coord = (coord == CW'(CELLS_PER_DIM - 1)) ? '0 : coord + CW'(1);
         end
         calc_cell[a*CW +: CW] = coord;
         calc_dst[a*CELL_ID_WIDTH +: CELL_ID_WIDTH] =
            {{(CELL_ID_WIDTH-CW){1'b0}}, coord} + CELL_ID_WIDTH'(1);
      end
      // An all-zero tuple means "empty slot" to the cache, so a real particle never writes one.
      if (calc_off == '0) calc_off[0] = 1'b1;
   end

   assign cell_changed = (calc_cell != cur_cell);

   always_comb begin
      state_nxt        = state;
      disp_ready       = 1'b0;
      MU_rden          = 1'b0;
      MU_wr_data_valid = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
      case (state)
         S_IDLE:      if (start) state_nxt = S_READ;
         S_READ:      begin busy = 1'b1; MU_rden = 1'b1; state_nxt = S_WAIT; end
         S_WAIT:      begin busy = 1'b1; state_nxt = (rd_tuple == '0) ? S_NEXT_CELL : S_CALC; end
         S_CALC:      begin busy = 1'b1; disp_ready = 1'b1; if (disp_valid) state_nxt = S_WRITE; end
         S_WRITE:     begin busy = 1'b1; MU_wr_data_valid = 1'b1;
                            state_nxt = last_slot ? S_NEXT_CELL : S_READ; end
         S_NEXT_CELL: begin busy = 1'b1; state_nxt = last_cell ? S_DONE : S_READ; end
         S_DONE:      begin done = 1'b1; state_nxt = S_IDLE; end
         default:     state_nxt = S_IDLE;
      endcase
   end

   assign Motion_Update_enable = busy;
   assign MU_rd_addr           = slot;
   assign MU_wr_data           = wr_data_q;
   assign MU_dst_cell          = dst_q;
   assign particles_moved      = moved_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cx        <= '0;
         cy        <= '0;
         cz        <= '0;
         slot      <= '0;
         tuple_q   <= '0;
         wr_data_q <= '0;
         dst_q     <= '0;
         moved_q   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (start) begin
               cx      <= '0;
               cy      <= '0;
               cz      <= '0;
               slot    <= '0;
               moved_q <= '0;
            end
            S_WAIT: tuple_q <= rd_tuple;
            S_CALC: if (disp_valid) begin
               wr_data_q <= calc_off;
               dst_q     <= calc_dst;
               if (cell_changed && moved_q != 16'hFFFF) moved_q <= moved_q + 16'd1;
            end
            S_WRITE: if (!last_slot) slot <= slot + PARTICLE_ID_WIDTH'(1);
            S_NEXT_CELL: begin
               slot <= '0;
               if (cx != CW'(CELLS_PER_DIM - 1)) begin
                  cx <= cx + CW'(1);
               end else begin
                  cx <= '0;
                  if (cy != CW'(CELLS_PER_DIM - 1)) begin
                     cy <= cy + CW'(1);
                  end else begin
                     cy <= '0;
                     cz <= (cz == CW'(CELLS_PER_DIM - 1)) ? '0 : cz + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
